demux1x8_sched: RTL and testbench

//  Round-robin scheduler that shares one 1-to-8 demux between 8 requesters.
//  - Picks one requester at a time and drives the demux select for DWELL cycles.
//  - Gates the serial data feeding the demux input.
//  - Sits directly in front of the 1x8 demux switch; sel and demux_in connect to its sel/in.

---
 rtl/demux1x8_sched.sv | 113 +++++++++++
 tb/tb_demux1x8_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux1x8_sched.sv
// Round-robin scheduler sharing one 1x8 demux among 8 requesters; grant held DWELL cycles, 1-clock req->gnt latency.
// Optional DEMUX_SCHED_FIXED_PRIO_EN: lowest set req index always wins instead of rotating.
module demux1x8_sched #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       data_in,
    output logic [2:0] sel,
    output logic       demux_in,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    logic [0:0]       state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             done_q, done_d;

    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       start;

    // Scan from the far end of the search order so the last hit is the first in order.
    always_comb begin
        win_idx  = 3'd0;
        scan_idx = 3'd0;
`ifdef DEMUX_SCHED_FIXED_PRIO_EN
        for (int i = 7; i >= 0; i--) begin
            scan_idx = 3'(i);
            if (req[scan_idx]) win_idx = scan_idx;
        end
`else
        // Offset 8 wraps to ptr itself, so the previous holder is searched last.
        for (int i = 8; i >= 1; i--) begin
            scan_idx = ptr_q + 3'(i);
            if (req[scan_idx]) win_idx = scan_idx;
        end
`endif
    end

    assign start = en && (|req);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GRANT;
                    sel_d   = win_idx;
                    gnt_d   = 8'd1 << win_idx;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = win_idx;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    // A holder that lets go early shortens the dwell to one more cycle.
                    if (!req[sel_q]) cnt_d = '0;
                    else             cnt_d = cnt_q - CNT_W'(1);
                end else if (start) begin
                    sel_d = win_idx;
                    gnt_d = 8'd1 << win_idx;
                    cnt_d = CNT_LOAD;
                    ptr_d = win_idx;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 8'h00;
                end
            end
        endcase
        done_d = (state_d == ST_GRANT) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            cnt_q   <= '0;
            ptr_q   <= 3'd7;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == ST_GRANT);
    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign demux_in = busy & data_in;

endmodule

// File: tb/tb_demux1x8_sched.sv
// Bench for demux1x8_sched: per-cycle expected outputs queued as stimulus is driven, popped after each edge.
module tb_demux1x8_sched;

    localparam int DWELL = 4;

`ifdef DEMUX_SCHED_FIXED_PRIO_EN
    localparam logic [2:0] R0 = 3'd0, R1 = 3'd0;
    localparam logic [2:0] E0 = 3'd0, E1 = 3'd0, E2 = 3'd0;
`else
    localparam logic [2:0] R0 = 3'd0, R1 = 3'd7;
    localparam logic [2:0] E0 = 3'd3, E1 = 3'd4, E2 = 3'd5;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       data_in;
    logic [2:0] sel;
    logic       demux_in;
    logic [7:0] gnt;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       busy;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    demux1x8_sched #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .data_in  (data_in),
        .sel      (sel),
        .demux_in (demux_in),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive inputs for the next edge, queue the cycle that edge should produce, then compare.
    task automatic cyc(input string tag, input logic [7:0] r, input logic e,
                       input logic b, input logic [2:0] s, input logic d);
        exp_t x;
        exp_t y;
        req = r;
        en  = e;
        x.busy = b;
        x.sel  = s;
        x.gnt  = b ? (8'd1 << s) : 8'h00;
        x.done = d;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        y = sb_q.pop_front();
        check({tag, ".busy"}, 32'(busy), 32'(y.busy));
        check({tag, ".sel"},  32'(sel),  32'(y.sel));
        check({tag, ".gnt"},  32'(gnt),  32'(y.gnt));
        check({tag, ".done"}, 32'(done), 32'(y.done));
    endtask

    task automatic dwell(input string tag, input logic [7:0] r, input logic [2:0] s);
        for (int i = 0; i < DWELL; i++)
            cyc($sformatf("%s.c%0d", tag, i + 1), r, 1'b1, 1'b1, s, i == DWELL - 1);
    endtask

    task automatic do_reset();
        req   = 8'h00;
        en    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        en      = 1'b1;
        req     = 8'hFF;
        data_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.sel",  32'(sel),  32'd0);
        check("rst.gnt",  32'(gnt),  32'h00);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold.gnt", 32'(gnt), 32'h00);
        rst_n = 1'b1;

        // Reset leaves ptr at 7, so index 0 wins first.
        dwell("t1", 8'hFF, 3'd0);
        cyc("t1.end", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

        dwell("t2", 8'h20, 3'd5);
        cyc("t2.end", 8'h00, 1'b1, 1'b0, 3'd5, 1'b0);
        cyc("t2.idle", 8'h00, 1'b1, 1'b0, 3'd5, 1'b0);

        do_reset();
        dwell("t3.g1", 8'h81, R0);
        dwell("t3.g2", 8'h81, R1);
        dwell("t3.g3", 8'h81, R0);
        dwell("t3.g4", 8'h81, R1);
        cyc("t3.end", 8'h00, 1'b1, 1'b0, R1, 1'b0);

        cyc("t4.c1", 8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
        cyc("t4.c2", 8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
        cyc("t4.c3", 8'h00, 1'b1, 1'b1, 3'd2, 1'b1);
        cyc("t4.c4", 8'h00, 1'b1, 1'b0, 3'd2, 1'b0);

        dwell("t5.g1", 8'hFF, E0);
        dwell("t5.g2", 8'hFF, E1);
        cyc("t5.g3c1", 8'hFF, 1'b1, 1'b1, E2, 1'b0);
        cyc("t5.g3c2", 8'hFF, 1'b0, 1'b1, E2, 1'b0);
        cyc("t5.g3c3", 8'hFF, 1'b0, 1'b1, E2, 1'b0);
        cyc("t5.g3c4", 8'hFF, 1'b0, 1'b1, E2, 1'b1);
        cyc("t5.end",  8'hFF, 1'b0, 1'b0, E2, 1'b0);
        cyc("t5.idle", 8'hFF, 1'b0, 1'b0, E2, 1'b0);

        cyc("t5r.c1", 8'h08, 1'b1, 1'b1, 3'd3, 1'b0);
        cyc("t5r.c2", 8'h08, 1'b1, 1'b1, 3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5r.async.busy", 32'(busy), 32'd0);
        check("t5r.async.gnt",  32'(gnt),  32'h00);
        check("t5r.async.sel",  32'(sel),  32'd0);
        check("t5r.async.done", 32'(done), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t5r.hold.done", 32'(done), 32'd0);
            check("t5r.hold.busy", 32'(busy), 32'd0);
        end
        req   = 8'h00;
        rst_n = 1'b1;

        data_in = 1'b1;
        #1;
        check("t6.idle.demux_in", 32'(demux_in), 32'd0);
        data_in = 1'b0;
        cyc("t6.c1", 8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
        data_in = 1'b1;
        #1;
        check("t6.busy.demux_in1", 32'(demux_in), 32'd1);
        data_in = 1'b0;
        #1;
        check("t6.busy.demux_in0", 32'(demux_in), 32'd0);
        cyc("t6.c2", 8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
        cyc("t6.c3", 8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
        cyc("t6.c4", 8'h40, 1'b1, 1'b1, 3'd6, 1'b1);
        cyc("t6.end", 8'h00, 1'b1, 1'b0, 3'd6, 1'b0);
        data_in = 1'b1;
        #1;
        check("t6.after.demux_in", 32'(demux_in), 32'd0);
        data_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
